fizzbuzz_formatter: RTL and testbench

//  Downstream stage of the fizzbuzz generator: consumes per-cycle records (number, is_fizz, is_buzz)
//  and renders each as an ASCII line on a byte stream with valid/ready backpressure.

---
 rtl/fizzbuzz_formatter.sv | 255 +++++++++++++++++++++++++
 tb/tb_fizzbuzz_formatter.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fizzbuzz_formatter.sv
`default_nettype none
// ============================================================================
// Module      : fizzbuzz_formatter
// Description : Renders fizzbuzz records (number, is_fizz, is_buzz) as ASCII
//               lines on a valid/ready byte stream. Records are queued in a
//               small FIFO; numbers are converted to decimal by a sequential
//               double-dabble engine (one shift step per cycle).
// Ports       : i_clk, i_rst_n (async, active-low)
//               i_valid, i_is_fizz, i_is_buzz, i_number  - record input
//               o_char, o_char_valid, i_char_ready        - byte stream
//               o_overflow (sticky record drop), o_busy   - status
// Revision    : 1.0 - initial release
// ============================================================================
module fizzbuzz_formatter #(
    parameter int G_LENGTH     = 100,
    parameter int G_FIFO_DEPTH = 4,
    parameter int G_DIGITS     = 3
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_valid,
    input  logic                        i_is_fizz,
    input  logic                        i_is_buzz,
    input  logic [$clog2(G_LENGTH)-1:0] i_number,
    output logic [7:0]                  o_char,
    output logic                        o_char_valid,
    input  logic                        i_char_ready,
    output logic                        o_overflow,
    output logic                        o_busy
);

    localparam int c_num_w = $clog2(G_LENGTH);
    localparam int c_ptr_w = $clog2(G_FIFO_DEPTH);
    localparam int c_rec_w = c_num_w + 2;
    localparam int c_bcd_w = 4 * G_DIGITS;
    localparam int c_dig_w = (G_DIGITS > 1) ? $clog2(G_DIGITS) : 1;
    // One index register serves both the letter position (0..7) and the digit position.
    localparam int c_idx_w = (c_dig_w > 3) ? c_dig_w : 3;
    localparam int c_cnt_w = $clog2(c_num_w + 1);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_load  = 3'd1;
    localparam logic [2:0] c_st_conv  = 3'd2;
    localparam logic [2:0] c_st_word  = 3'd3;
    localparam logic [2:0] c_st_digit = 3'd4;
    localparam logic [2:0] c_st_nl    = 3'd5;

    generate
        if ((10 ** G_DIGITS) <= ((2 ** c_num_w) - 1)) begin : g_err_digits
            $error("fizzbuzz_formatter: G_DIGITS too small for the number width");
        end
        if ((G_FIFO_DEPTH < 2) || ((G_FIFO_DEPTH & (G_FIFO_DEPTH - 1)) != 0)) begin : g_err_depth
            $error("fizzbuzz_formatter: G_FIFO_DEPTH must be a power of 2 and >= 2");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Record FIFO (extra pointer bit distinguishes full from empty)
    // ------------------------------------------------------------------------
    logic [c_rec_w-1:0] r_mem [G_FIFO_DEPTH];
    logic [c_ptr_w:0]   r_wr_ptr;
    logic [c_ptr_w:0]   r_rd_ptr;
    logic               r_overflow;
    logic [2:0]         r_state;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_ptr_w] != r_rd_ptr[c_ptr_w]) &&
                     (r_wr_ptr[c_ptr_w-1:0] == r_rd_ptr[c_ptr_w-1:0]);
    assign w_pop   = (r_state == c_st_idle) && !w_empty;
    // A full FIFO still accepts when the FSM is draining an entry this cycle.
    assign w_push  = i_valid && (!w_full || w_pop);

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_ptr_w-1:0]] <= {i_is_fizz, i_is_buzz, i_number};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (i_valid && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Working registers and formatter FSM
    // ------------------------------------------------------------------------
    logic               r_fizz;
    logic               r_buzz;
    logic [c_num_w-1:0] r_shift;
    logic [c_bcd_w-1:0] r_bcd;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_idx_w-1:0] r_idx;

    logic [c_bcd_w-1:0] w_adj;
    logic [c_bcd_w-1:0] w_bcd_next;
    logic [c_num_w-1:0] w_shift_next;
    logic [c_idx_w-1:0] w_msnz;
    logic [3:0]         w_nibble;
    logic [7:0]         w_letter;
    logic [c_idx_w-1:0] w_last_letter;
    logic               w_xfer;

    assign w_xfer = o_char_valid && i_char_ready;

    // Letters are indexed into "FizzBuzz"; a buzz-only line starts at 4.
    assign w_last_letter = (r_fizz && !r_buzz) ? c_idx_w'(3) : c_idx_w'(7);

    // One double-dabble step plus the position of the leading non-zero digit
    // of the resulting value (used when this is the final step).
    always_comb begin
        w_adj = r_bcd;
        for (int k = 0; k < G_DIGITS; k++) begin
            if (r_bcd[4*k +: 4] >= 4'd5) begin
                w_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
            end
        end
        {w_bcd_next, w_shift_next} = {w_adj, r_shift} << 1;
        w_msnz = '0;
        for (int k = 0; k < G_DIGITS; k++) begin
            if (w_bcd_next[4*k +: 4] != 4'd0) begin
                w_msnz = c_idx_w'(k);
            end
        end
    end

    always_comb begin
        w_nibble = 4'd0;
        for (int k = 0; k < G_DIGITS; k++) begin
            if (r_idx == c_idx_w'(k)) begin
                w_nibble = r_bcd[4*k +: 4];
            end
        end
    end

    always_comb begin
        case (r_idx[2:0])
            3'd0:    w_letter = 8'h46; // F
            3'd1:    w_letter = 8'h69; // i
            3'd4:    w_letter = 8'h42; // B
            3'd5:    w_letter = 8'h75; // u
            default: w_letter = 8'h7A; // z
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= c_st_idle;
            r_fizz  <= 1'b0;
            r_buzz  <= 1'b0;
            r_shift <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (!w_empty) begin
                        {r_fizz, r_buzz, r_shift} <= r_mem[r_rd_ptr[c_ptr_w-1:0]];
                        r_state <= c_st_load;
                    end
                end
                c_st_load: begin
                    if (r_fizz || r_buzz) begin
                        r_idx   <= r_fizz ? '0 : c_idx_w'(4);
                        r_state <= c_st_word;
                    end else begin
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                        r_state <= c_st_conv;
                    end
                end
                c_st_conv: begin
                    r_bcd   <= w_bcd_next;
                    r_shift <= w_shift_next;
                    r_cnt   <= r_cnt + c_cnt_w'(1);
                    if (r_cnt == c_cnt_w'(c_num_w - 1)) begin
                        r_idx   <= w_msnz;
                        r_state <= c_st_digit;
                    end
                end
                c_st_word: begin
                    if (w_xfer) begin
                        if (r_idx == w_last_letter) begin
                            r_state <= c_st_nl;
                        end else begin
                            r_idx <= r_idx + c_idx_w'(1);
                        end
                    end
                end
                c_st_digit: begin
                    if (w_xfer) begin
                        if (r_idx == '0) begin
                            r_state <= c_st_nl;
                        end else begin
                            r_idx <= r_idx - c_idx_w'(1);
                        end
                    end
                end
                c_st_nl: begin
                    if (w_xfer) begin
                        r_state <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    // Outputs decode registered state only, so they stay stable under backpressure.
    always_comb begin
        o_char       = 8'h00;
        o_char_valid = 1'b0;
        case (r_state)
            c_st_word: begin
                o_char       = w_letter;
                o_char_valid = 1'b1;
            end
            c_st_digit: begin
                o_char       = 8'h30 + {4'h0, w_nibble};
                o_char_valid = 1'b1;
            end
            c_st_nl: begin
                o_char       = 8'h0A;
                o_char_valid = 1'b1;
            end
            default: begin
                o_char       = 8'h00;
                o_char_valid = 1'b0;
            end
        endcase
    end

    assign o_overflow = r_overflow;
    assign o_busy     = !w_empty || (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_fizzbuzz_formatter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fizzbuzz_formatter
// Description : Self-checking bench for fizzbuzz_formatter: table of records
//               with expected lines, directed multi-cycle sequences, and a
//               randomized run against a line-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fizzbuzz_formatter;

    localparam int LEN    = 100;
    localparam int DEPTH  = 4;
    localparam int DIGITS = 3;
    localparam int W      = $clog2(LEN);

    logic         i_clk = 1'b0;
    logic         i_rst_n;
    logic         i_valid;
    logic         i_is_fizz;
    logic         i_is_buzz;
    logic [W-1:0] i_number;
    logic [7:0]   o_char;
    logic         o_char_valid;
    logic         i_char_ready;
    logic         o_overflow;
    logic         o_busy;

    fizzbuzz_formatter #(
        .G_LENGTH     (LEN),
        .G_FIFO_DEPTH (DEPTH),
        .G_DIGITS     (DIGITS)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_valid      (i_valid),
        .i_is_fizz    (i_is_fizz),
        .i_is_buzz    (i_is_buzz),
        .i_number     (i_number),
        .o_char       (o_char),
        .o_char_valid (o_char_valid),
        .i_char_ready (i_char_ready),
        .o_overflow   (o_overflow),
        .o_busy       (o_busy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int    num;
        bit    fz;
        bit    bz;
        string exp;
    } vec_t;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    bit         model_en   = 1'b0;
    bit         hold_prev  = 1'b0;
    logic [7:0] prev_char  = 8'h00;
    int         outstanding = 0;
    bit         model_ovf  = 1'b0;

    vec_t       tbl[8];
    vec_t       t6[6];
    logic [7:0] fb[9];
    string      s;
    int         n;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic string vis(input string str);
        string r;
        r = "";
        for (int i = 0; i < str.len(); i++) begin
            if (str[i] == 8'h0A) r = {r, "\\n"};
            else r = $sformatf("%s%c", r, str[i]);
        end
        return r;
    endfunction

    task automatic chk_str(input string name, input string act, input string exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got \"%s\", required \"%s\"", name, vis(act), vis(exp));
        end
    endtask

    // Reference rendering of one record, straight from the line-format rules.
    function automatic string fmt(input int num, input bit f, input bit b);
        if (f && b) return "FizzBuzz\n";
        if (f)      return "Fizz\n";
        if (b)      return "Buzz\n";
        return $sformatf("%0d\n", num);
    endfunction

    // Record-level model: a record is kept when fewer than DEPTH+1 lines are
    // outstanding (DEPTH queued + one being rendered); a line stops being
    // outstanding the cycle after its newline is transferred.
    task automatic model_step();
        string    line;
        logic [7:0] eb;
        chk("overflow_flag", {31'd0, o_overflow}, {31'd0, model_ovf});
        if (i_valid) begin
            if (outstanding < DEPTH + 1) begin
                line = fmt(int'(i_number), i_is_fizz, i_is_buzz);
                for (int i = 0; i < line.len(); i++) exp_q.push_back(line[i]);
                outstanding++;
            end else begin
                model_ovf = 1'b1;
            end
        end
        if (o_char_valid && i_char_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rand_extra_byte: got 0x%0h, required no byte", o_char);
            end else begin
                eb = exp_q.pop_front();
                chk("rand_byte", {24'd0, o_char}, {24'd0, eb});
                if (eb == 8'h0A) outstanding--;
            end
        end
    endtask

    // One clock: sample at the falling edge, return 1 time unit after the rising edge.
    task automatic tick();
        @(negedge i_clk);
        if (hold_prev) begin
            chk("hold_valid", {31'd0, o_char_valid}, 32'd1);
            chk("hold_char", {24'd0, o_char}, {24'd0, prev_char});
        end
        hold_prev = o_char_valid && !i_char_ready;
        prev_char = o_char;
        if (model_en) model_step();
        else if (o_char_valid && i_char_ready) got_q.push_back(o_char);
        @(posedge i_clk);
        #1;
    endtask

    task automatic push(input int num, input bit f, input bit b);
        i_valid   = 1'b1;
        i_number  = W'(num);
        i_is_fizz = f;
        i_is_buzz = b;
        tick();
        i_valid   = 1'b0;
    endtask

    function automatic bit has_nl();
        foreach (got_q[k]) if (got_q[k] == 8'h0A) return 1'b1;
        return 1'b0;
    endfunction

    task automatic get_line(input string name, output string line);
        int         cnt;
        logic [7:0] b;
        cnt  = 0;
        line = "";
        while (!has_nl() && cnt < 300) begin
            tick();
            cnt++;
        end
        if (!has_nl()) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: got %0d bytes and no newline in 300 cycles, required a full line", name, got_q.size());
        end else begin
            do begin
                b    = got_q.pop_front();
                line = $sformatf("%s%c", line, b);
            end while (b != 8'h0A);
        end
    endtask

    task automatic do_reset();
        i_rst_n   = 1'b0;
        hold_prev = 1'b0;
        tick();
        i_rst_n   = 1'b1;
        got_q.delete();
    endtask

    initial begin
        tbl[0] = '{num: 0,   fz: 0, bz: 0, exp: "0\n"};
        tbl[1] = '{num: 100, fz: 0, bz: 0, exp: "100\n"};
        tbl[2] = '{num: 9,   fz: 1, bz: 0, exp: "Fizz\n"};
        tbl[3] = '{num: 10,  fz: 0, bz: 1, exp: "Buzz\n"};
        tbl[4] = '{num: 7,   fz: 0, bz: 0, exp: "7\n"};
        tbl[5] = '{num: 15,  fz: 1, bz: 1, exp: "FizzBuzz\n"};
        tbl[6] = '{num: 127, fz: 0, bz: 0, exp: "127\n"};
        tbl[7] = '{num: 42,  fz: 0, bz: 0, exp: "42\n"};

        t6[0] = '{num: 1,  fz: 0, bz: 0, exp: "1\n"};
        t6[1] = '{num: 3,  fz: 1, bz: 0, exp: "Fizz\n"};
        t6[2] = '{num: 5,  fz: 0, bz: 1, exp: "Buzz\n"};
        t6[3] = '{num: 15, fz: 1, bz: 1, exp: "FizzBuzz\n"};
        t6[4] = '{num: 22, fz: 0, bz: 0, exp: "22\n"};
        t6[5] = '{num: 33, fz: 1, bz: 0, exp: "Fizz\n"};

        fb = '{8'h46, 8'h69, 8'h7A, 8'h7A, 8'h42, 8'h75, 8'h7A, 8'h7A, 8'h0A};

        i_rst_n      = 1'b0;
        i_valid      = 1'b0;
        i_is_fizz    = 1'b0;
        i_is_buzz    = 1'b0;
        i_number     = '0;
        i_char_ready = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        chk("reset_valid", {31'd0, o_char_valid}, 32'd0);
        chk("reset_char", {24'd0, o_char}, 32'd0);
        chk("reset_overflow", {31'd0, o_overflow}, 32'd0);
        chk("reset_busy", {31'd0, o_busy}, 32'd0);
        i_rst_n = 1'b1;
        tick();

        // Single number: latency from pop to first digit, then idle.
        push(7, 1'b0, 1'b0);
        n = 0;
        while (!o_char_valid && n < 40) begin
            tick();
            n++;
        end
        chk("digit_latency", n, W + 2);
        chk("first_digit", {24'd0, o_char}, 32'h37);
        get_line("line_7", s);
        chk_str("line_7", s, "7\n");
        chk("idle_after_7", {31'd0, o_busy}, 32'd0);

        // FizzBuzz: 9 back-to-back transfers.
        push(15, 1'b1, 1'b1);
        n = 0;
        while (!o_char_valid && n < 40) begin
            tick();
            n++;
        end
        chk("word_latency", n, 2);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("fb_valid_%0d", i), {31'd0, o_char_valid}, 32'd1);
            chk($sformatf("fb_char_%0d", i), {24'd0, o_char}, {24'd0, fb[i]});
            tick();
        end
        get_line("line_fb", s);
        chk_str("line_fb", s, "FizzBuzz\n");

        // Four records back-to-back, rendered in order.
        for (int i = 0; i < 4; i++) push(tbl[i].num, tbl[i].fz, tbl[i].bz);
        for (int i = 0; i < 4; i++) begin
            get_line($sformatf("b2b_%0d", i), s);
            chk_str($sformatf("b2b_%0d", i), s, tbl[i].exp);
        end

        // Whole table, one record at a time.
        for (int i = 0; i < 8; i++) begin
            push(tbl[i].num, tbl[i].fz, tbl[i].bz);
            get_line($sformatf("tbl_%0d", i), s);
            chk_str($sformatf("tbl_%0d", i), s, tbl[i].exp);
        end

        // Backpressure at the second byte of "Fizz".
        push(9, 1'b1, 1'b0);
        n = 0;
        while (!o_char_valid && n < 40) begin
            tick();
            n++;
        end
        tick();
        i_char_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall_char_%0d", i), {24'd0, o_char}, 32'h69);
            tick();
        end
        i_char_ready = 1'b1;
        get_line("line_stall", s);
        chk_str("line_stall", s, "Fizz\n");

        // Reset in the middle of a FizzBuzz line.
        push(15, 1'b1, 1'b1);
        repeat (3) tick();
        chk("midline_char", {24'd0, o_char}, 32'h69);
        i_rst_n   = 1'b0;
        hold_prev = 1'b0;
        #1;
        chk("rst_mid_valid", {31'd0, o_char_valid}, 32'd0);
        chk("rst_mid_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_mid_overflow", {31'd0, o_overflow}, 32'd0);
        tick();
        i_rst_n = 1'b1;
        got_q.delete();
        repeat (5) tick();
        chk("post_rst_valid", {31'd0, o_char_valid}, 32'd0);
        chk("post_rst_busy", {31'd0, o_busy}, 32'd0);
        chk("post_rst_bytes", got_q.size(), 32'd0);

        // Overflow: six records with the sink stalled.
        i_char_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) chk("ovf_before_drop", {31'd0, o_overflow}, 32'd0);
            push(t6[i].num, t6[i].fz, t6[i].bz);
        end
        chk("ovf_after_drop", {31'd0, o_overflow}, 32'd1);
        repeat (20) tick();
        chk("ovf_busy", {31'd0, o_busy}, 32'd1);
        i_char_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            get_line($sformatf("ovf_line_%0d", i), s);
            chk_str($sformatf("ovf_line_%0d", i), s, t6[i].exp);
        end
        repeat (40) tick();
        chk("ovf_no_sixth", got_q.size(), 32'd0);
        chk("ovf_sticky", {31'd0, o_overflow}, 32'd1);
        chk("ovf_idle", {31'd0, o_busy}, 32'd0);

        do_reset();
        chk("ovf_cleared", {31'd0, o_overflow}, 32'd0);

        // Randomized traffic against the reference model.
        exp_q.delete();
        outstanding = 0;
        model_ovf   = 1'b0;
        model_en    = 1'b1;
        for (int c = 0; c < 800; c++) begin
            i_valid      = (c < 400) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
            i_number     = W'($urandom_range(0, (1 << W) - 1));
            i_is_fizz    = 1'($urandom_range(0, 1));
            i_is_buzz    = 1'($urandom_range(0, 1));
            i_char_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        i_valid      = 1'b0;
        i_char_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            tick();
            n++;
        end
        chk("rand_drained", exp_q.size(), 32'd0);
        tick();
        model_en = 1'b0;
        chk("rand_idle_busy", {31'd0, o_busy}, 32'd0);
        chk("rand_overflow_final", {31'd0, o_overflow}, {31'd0, model_ovf});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
